// File: rtl/psram_define.sv
// Shared definitions for the PSRAM transfer sequencer.
//   xfer_state_e : sequencer FSM states (also visible on the debug state port)
//   IRQ_DONE     : bit of the interrupt-enable vector for the done flag
//   IRQ_TMO      : bit of the interrupt-enable vector for the timeout flag
package psram_define;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_RECOV = 2'd2
    } xfer_state_e;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_TMO  = 1;

endpackage

// File: rtl/dffer.sv
// Register with load enable and asynchronous active-low reset to zero.
//   clk   : clock
//   rst_n : async active-low reset
//   en    : load enable; q holds when low
//   d / q : next / current value, W bits
module dffer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/dffr.sv
// Plain register with asynchronous active-low reset to zero.
//   clk   : clock
//   rst_n : async active-low reset
//   d / q : next / current value, W bits
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/psram_xfer_seq.sv
// PSRAM transfer sequencer. Arbitrates between a register-side config
// request and a bus request, issues one transfer to the PSRAM core, waits
// for completion (or a timeout), then enforces a recovery gap.
//   clk_i / rst_n_i      : clock, async active-low reset
//   cfg_*_i              : enable, recovery, timeout, irq enables, config request
//   cfg_rdata_o/busy/... : last config read data, busy, sticky done / timeout
//   bus_*                : bus request (valid/ready) and completion (done/err/rdata)
//   xfer_*               : request to the PSRAM core, xfer_ready_i = completion
//   irq_o                : registered interrupt
//   dbg_state_o          : current FSM state
//
// Handshakes: bus_valid_i/bus_ready_o transfer a request on a clock edge
// where both are high; bus_ready_o never depends on bus_valid_i. Towards
// the core, xfer_valid_o and every xfer_* field stay stable until the edge
// where xfer_ready_i is high (or the timeout aborts the transfer).
module psram_xfer_seq
    import psram_define::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cfg_en_i,
    input  logic [7:0]              cfg_recy_i,
    input  logic [TMO_WIDTH-1:0]    cfg_tmo_i,
    input  logic [1:0]              cfg_irq_en_i,
    input  logic                    cfg_req_i,
    input  logic                    cfg_rdwr_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
    input  logic [8*DATA_BYTES-1:0] cfg_wdata_i,
    input  logic                    cfg_clr_i,
    output logic [8*DATA_BYTES-1:0] cfg_rdata_o,
    output logic                    cfg_busy_o,
    output logic                    cfg_done_o,
    output logic                    cfg_tmo_o,
    input  logic                    bus_valid_i,
    output logic                    bus_ready_o,
    input  logic                    bus_rdwr_i,
    input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
    input  logic [8*DATA_BYTES-1:0] bus_wdata_i,
    input  logic [DATA_BYTES-1:0]   bus_wmask_i,
    output logic                    bus_done_o,
    output logic                    bus_err_o,
    output logic [8*DATA_BYTES-1:0] bus_rdata_o,
    output logic                    xfer_valid_o,
    output logic                    xfer_rdwr_o,
    output logic                    xfer_cfg_o,
    output logic [ADDR_WIDTH-1:0]   xfer_addr_o,
    output logic [8*DATA_BYTES-1:0] xfer_wdata_o,
    output logic [DATA_BYTES-1:0]   xfer_wmask_o,
    input  logic                    xfer_ready_i,
    input  logic [8*DATA_BYTES-1:0] xfer_rdata_i,
    output logic                    irq_o,
    output logic [1:0]              dbg_state_o
);

    localparam int DW = 8 * DATA_BYTES;

    xfer_state_e state_q, state_d;
    logic        alive_q;   // low during reset so bus_ready_o reads 0 there too
    logic        cfg_accept, bus_accept, xfer_cmpl, tmo_hit, recov_end;

    logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]           rec_cnt_q, rec_cnt_d;
    logic                 rec_cnt_en;

    logic [DW-1:0] cfg_rdata_q, bus_rdata_q;
    logic          done_q, tmo_q, bus_done_q, bus_err_q, irq_q;

    // Config wins over a coincident bus request; cfg_req_i outside IDLE is dropped.
    assign cfg_accept  = (state_q == ST_IDLE) && alive_q && cfg_en_i && cfg_req_i;
    assign bus_ready_o = (state_q == ST_IDLE) && alive_q && cfg_en_i && !cfg_req_i;
    assign bus_accept  = bus_ready_o && bus_valid_i;

    // Completion on the limit cycle counts as success, so tmo_hit needs !xfer_ready_i.
    assign xfer_cmpl = (state_q == ST_XFER) && xfer_ready_i;
    assign tmo_hit   = (state_q == ST_XFER) && !xfer_ready_i &&
                       (cfg_tmo_i != '0) && (tmo_cnt_q == cfg_tmo_i);
    // The first RECOV cycle sees count 1, so cfg_recy_i of 0 or 1 both give one cycle.
    assign recov_end = (state_q == ST_RECOV) && (rec_cnt_q >= cfg_recy_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_accept || bus_accept) state_d = ST_XFER;
            ST_XFER:  if (xfer_cmpl || tmo_hit)     state_d = ST_RECOV;
            ST_RECOV: if (recov_end)                state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // XFER cycle counter: preloaded with 1 outside XFER so the first XFER cycle reads 1.
    assign tmo_cnt_d = (state_q == ST_XFER) ? tmo_cnt_q + TMO_WIDTH'(1) : TMO_WIDTH'(1);

    dffr #(.W(TMO_WIDTH)) u_tmo_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (tmo_cnt_d),
        .q     (tmo_cnt_q)
    );

    // Recovery counter: loaded with 1 while in XFER, counts up through RECOV.
    assign rec_cnt_en = (state_q != ST_IDLE);
    assign rec_cnt_d  = (state_q == ST_RECOV) ? rec_cnt_q + 8'd1 : 8'd1;

    dffer #(.W(8)) u_rec_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (rec_cnt_en),
        .d     (rec_cnt_d),
        .q     (rec_cnt_q)
    );

    // Request fields are captured at acceptance and held for the whole XFER.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            xfer_cfg_o   <= 1'b0;
            xfer_rdwr_o  <= 1'b0;
            xfer_addr_o  <= '0;
            xfer_wdata_o <= '0;
            xfer_wmask_o <= '0;
        end else if (cfg_accept) begin
            xfer_cfg_o   <= 1'b1;
            xfer_rdwr_o  <= cfg_rdwr_i;
            xfer_addr_o  <= cfg_addr_i;
            xfer_wdata_o <= cfg_wdata_i;
            xfer_wmask_o <= cfg_rdwr_i ? '0 : '1;
        end else if (bus_accept) begin
            xfer_cfg_o   <= 1'b0;
            xfer_rdwr_o  <= bus_rdwr_i;
            xfer_addr_o  <= bus_addr_i;
            xfer_wdata_o <= bus_wdata_i;
            xfer_wmask_o <= bus_wmask_i;
        end
    end

    // Status and completion registers; a flag set beats a coincident clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            cfg_rdata_q <= '0;
            bus_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (xfer_cmpl && xfer_cfg_o) done_q <= 1'b1;
            else if (cfg_clr_i)          done_q <= 1'b0;
            if (tmo_hit)                 tmo_q  <= 1'b1;
            else if (cfg_clr_i)          tmo_q  <= 1'b0;
            if (xfer_cmpl && xfer_cfg_o && xfer_rdwr_o)  cfg_rdata_q <= xfer_rdata_i;
            if (xfer_cmpl && !xfer_cfg_o && xfer_rdwr_o) bus_rdata_q <= xfer_rdata_i;
            bus_done_q <= (xfer_cmpl || tmo_hit) && !xfer_cfg_o;
            bus_err_q  <= tmo_hit && !xfer_cfg_o;
            irq_q      <= (done_q & cfg_irq_en_i[IRQ_DONE]) | (tmo_q & cfg_irq_en_i[IRQ_TMO]);
        end
    end

    assign xfer_valid_o = (state_q == ST_XFER);
    assign cfg_busy_o   = (state_q != ST_IDLE);
    assign cfg_done_o   = done_q;
    assign cfg_tmo_o    = tmo_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign bus_done_o   = bus_done_q;
    assign bus_err_o    = bus_err_q;
    assign bus_rdata_o  = bus_rdata_q;
    assign irq_o        = irq_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_psram_xfer_seq.sv
// Self-checking bench for psram_xfer_seq (default parameters).
module tb_psram_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_recy = '0;
  logic [15:0] cfg_tmo = '0;
  logic [1:0]  cfg_irq_en = '0;
  logic        cfg_req = 1'b0, cfg_rdwr = 1'b0, cfg_clr = 1'b0;
  logic [31:0] cfg_addr = '0, cfg_wdata = '0;
  logic        bus_valid = 1'b0, bus_rdwr = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0]  bus_wmask = '0;
  logic        xfer_ready = 1'b0;
  logic [31:0] xfer_rdata = '0;

  logic [31:0] cfg_rdata_o, bus_rdata_o, xfer_addr_o, xfer_wdata_o;
  logic        cfg_busy_o, cfg_done_o, cfg_tmo_o, bus_ready_o, bus_done_o, bus_err_o;
  logic        xfer_valid_o, xfer_rdwr_o, xfer_cfg_o, irq_o;
  logic [3:0]  xfer_wmask_o;
  logic [1:0]  dbg_state_o;

  psram_xfer_seq dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_en_i(cfg_en), .cfg_recy_i(cfg_recy), .cfg_tmo_i(cfg_tmo), .cfg_irq_en_i(cfg_irq_en),
    .cfg_req_i(cfg_req), .cfg_rdwr_i(cfg_rdwr), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_clr_i(cfg_clr), .cfg_rdata_o(cfg_rdata_o), .cfg_busy_o(cfg_busy_o),
    .cfg_done_o(cfg_done_o), .cfg_tmo_o(cfg_tmo_o),
    .bus_valid_i(bus_valid), .bus_ready_o(bus_ready_o), .bus_rdwr_i(bus_rdwr),
    .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_wmask_i(bus_wmask),
    .bus_done_o(bus_done_o), .bus_err_o(bus_err_o), .bus_rdata_o(bus_rdata_o),
    .xfer_valid_o(xfer_valid_o), .xfer_rdwr_o(xfer_rdwr_o), .xfer_cfg_o(xfer_cfg_o),
    .xfer_addr_o(xfer_addr_o), .xfer_wdata_o(xfer_wdata_o), .xfer_wmask_o(xfer_wmask_o),
    .xfer_ready_i(xfer_ready), .xfer_rdata_i(xfer_rdata), .irq_o(irq_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [69:0] exp_xfer_q[$];  // {cfg, rdwr, addr, wdata, wmask}
  logic [33:0] exp_bus_q[$];   // {err, check_rdata, rdata}
  int busy_run = 0;
  int last_busy_len = 0;

  logic [255:0] all_out;
  assign all_out = 256'({cfg_rdata_o, cfg_busy_o, cfg_done_o, cfg_tmo_o, bus_ready_o,
                         bus_done_o, bus_err_o, bus_rdata_o, xfer_valid_o, xfer_rdwr_o,
                         xfer_cfg_o, xfer_addr_o, xfer_wdata_o, xfer_wmask_o, irq_o,
                         dbg_state_o});

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic        prev_valid = 1'b0;
  logic        prev_done = 1'b0;
  logic [69:0] cur_exp_xfer = '0;

  always @(negedge clk) begin
    if (xfer_valid_o && !prev_valid) begin
      if (exp_xfer_q.size() == 0) begin
        check("xfer_unexpected", 1'b1, 1'b0);
      end else begin
        cur_exp_xfer = exp_xfer_q.pop_front();
        check("xfer_req", {xfer_cfg_o, xfer_rdwr_o, xfer_addr_o, xfer_wdata_o, xfer_wmask_o},
              cur_exp_xfer);
      end
    end else if (xfer_valid_o) begin
      check("xfer_stable", {xfer_cfg_o, xfer_rdwr_o, xfer_addr_o, xfer_wdata_o, xfer_wmask_o},
            cur_exp_xfer);
    end
    prev_valid = xfer_valid_o;
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (bus_done_o) begin
      if (prev_done) check("bus_done_width", 1'b1, 1'b0);
      if (exp_bus_q.size() == 0) begin
        check("bus_done_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_bus_q.pop_front();
        check("bus_err", bus_err_o, e[33]);
        if (e[32]) check("bus_rdata", bus_rdata_o, e[31:0]);
      end
    end
    prev_done = bus_done_o;
  end

  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else if (cfg_busy_o) busy_run++;
    else if (busy_run > 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cfg(input logic rd, input logic [31:0] a, input logic [31:0] d);
    exp_xfer_q.push_back({1'b1, rd, a, d, rd ? 4'h0 : 4'hF});
    cfg_req = 1'b1; cfg_rdwr = rd; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_req = 1'b0;
  endtask

  task automatic issue_bus(input logic rd, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    exp_xfer_q.push_back({1'b0, rd, a, d, m});
    bus_valid = 1'b1; bus_rdwr = rd; bus_addr = a; bus_wdata = d; bus_wmask = m;
    for (int i = 0; i < 30 && !bus_ready_o; i++) tick();
    check("bus_accept", bus_ready_o, 1'b1);
    tick();
    bus_valid = 1'b0;
  endtask

  // Core responder: assert xfer_ready_i during the n-th XFER cycle.
  task automatic core_respond(input int n, input logic [31:0] data);
    for (int i = 0; i < 30 && !xfer_valid_o; i++) tick();
    check("wait_xfer_valid", xfer_valid_o, 1'b1);
    repeat (n - 1) tick();
    xfer_ready = 1'b1; xfer_rdata = data;
    tick();
    xfer_ready = 1'b0; xfer_rdata = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && cfg_busy_o; i++) tick();
    check("wait_idle", cfg_busy_o, 1'b0);
    tick();
  endtask

  task automatic clear_flags();
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", all_out, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("ready_when_disabled", bus_ready_o, 1'b0);
    cfg_en = 1'b1;
    #1 check("ready_idle_enabled", bus_ready_o, 1'b1);

    // Config write, ready on 3rd XFER cycle, 2 recovery cycles
    cfg_recy = 8'd2;
    issue_cfg(1'b0, 32'h10, 32'hA5A5A5A5);
    core_respond(3, 32'h0);
    check("t1_done", cfg_done_o, 1'b1);
    wait_idle();
    check("t1_busy_len", last_busy_len, 5);
    check("t1_irq_disabled", irq_o, 1'b0);

    // Config read with done interrupt enabled
    clear_flags();
    check("t2_clr_done", cfg_done_o, 1'b0);
    cfg_irq_en = 2'b01;
    issue_cfg(1'b1, 32'h20, 32'h0);
    core_respond(1, 32'h12345678);
    check("t2_rdata", cfg_rdata_o, 32'h12345678);
    check("t2_done", cfg_done_o, 1'b1);
    check("t2_irq_not_yet", irq_o, 1'b0);
    tick();
    check("t2_irq", irq_o, 1'b1);
    wait_idle();
    cfg_irq_en = 2'b00;
    clear_flags();

    // Config and bus request in the same cycle
    exp_xfer_q.push_back({1'b1, 1'b0, 32'h30, 32'hDEADBEEF, 4'hF});
    exp_xfer_q.push_back({1'b0, 1'b1, 32'h40, 32'h11, 4'h5});
    exp_bus_q.push_back({1'b0, 1'b1, 32'hCAFEF00D});
    cfg_req = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h30; cfg_wdata = 32'hDEADBEEF;
    bus_valid = 1'b1; bus_rdwr = 1'b1; bus_addr = 32'h40; bus_wdata = 32'h11; bus_wmask = 4'h5;
    #1 check("t3_ready_lose", bus_ready_o, 1'b0);
    tick();
    cfg_req = 1'b0;
    core_respond(2, 32'h0);
    for (int i = 0; i < 20 && !bus_ready_o; i++) begin
      check("t3_busy_while_blocked", cfg_busy_o, 1'b1);
      tick();
    end
    check("t3_ready_back", bus_ready_o, 1'b1);
    check("t3_idle", cfg_busy_o, 1'b0);
    tick();
    bus_valid = 1'b0;
    core_respond(1, 32'hCAFEF00D);
    wait_idle();

    // Bus write with partial mask, zero recovery
    cfg_recy = 8'd0;
    exp_bus_q.push_back({1'b0, 1'b0, 32'h0});
    issue_bus(1'b0, 32'h50, 32'h55AA55AA, 4'h3);
    core_respond(1, 32'h0);
    wait_idle();
    check("t3b_busy_len", last_busy_len, 2);
    check("t3b_rdata_held", bus_rdata_o, 32'hCAFEF00D);

    // Timeout on a bus read
    cfg_tmo = 16'd5;
    cfg_recy = 8'd1;
    exp_bus_q.push_back({1'b1, 1'b0, 32'h0});
    issue_bus(1'b1, 32'h80, 32'h0, 4'hF);
    n = 0;
    for (int i = 0; i < 20 && xfer_valid_o; i++) begin
      n++;
      tick();
    end
    check("t4_valid_cycles", n, 5);
    check("t4_tmo_flag", cfg_tmo_o, 1'b1);
    wait_idle();

    // Ready on the limit cycle counts as completion
    clear_flags();
    check("t4_clr_tmo", cfg_tmo_o, 1'b0);
    exp_bus_q.push_back({1'b0, 1'b1, 32'h0BADF00D});
    issue_bus(1'b1, 32'h84, 32'h0, 4'hF);
    core_respond(5, 32'h0BADF00D);
    wait_idle();
    check("t4_no_tmo_on_limit", cfg_tmo_o, 1'b0);
    cfg_tmo = 16'd0;

    // Clear vs set, enable drop mid-transfer, cfg_req ignored while busy
    clear_flags();
    issue_cfg(1'b0, 32'h60, 32'h01020304);
    cfg_en = 1'b0;
    cfg_req = 1'b1; cfg_addr = 32'h99;
    tick();
    cfg_req = 1'b0;
    xfer_ready = 1'b1; cfg_clr = 1'b1;
    tick();
    xfer_ready = 1'b0; cfg_clr = 1'b0;
    check("t5_set_beats_clr", cfg_done_o, 1'b1);
    wait_idle();
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    check("t5_disabled_ignored", cfg_busy_o, 1'b0);
    cfg_en = 1'b1;
    clear_flags();
    check("t5_clr_alone", cfg_done_o, 1'b0);

    // Reset in the middle of a transfer
    issue_bus(1'b0, 32'h70, 32'hAAAA5555, 4'h1);
    tick();
    rst_n = 1'b0;
    #1 check("t6_reset_outputs", all_out, '0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    issue_cfg(1'b1, 32'h74, 32'h0);
    core_respond(2, 32'h87654321);
    check("t6_rdata_after_reset", cfg_rdata_o, 32'h87654321);
    check("t6_done_after_reset", cfg_done_o, 1'b1);
    wait_idle();

    repeat (3) tick();
    check("xfer_queue_empty", exp_xfer_q.size(), 0);
    check("bus_queue_empty", exp_bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
